// File: rtl/tx_serial_7o1_if.sv
// Bus between the ASCII transmission control unit and the 7O1 serial transmitter.
//
// Handshake: partida is a start request. The transmitter samples it only while idle
// (repouso), and there is no ready signal. When partida is accepted, dados_ascii
// must be held stable through the following cycle. A request that arrives while
// the transmitter is busy is dropped, not queued. pronto is a one-cycle completion
// pulse that is issued after the stop bit has finished on saida_serial.
interface tx_serial_7o1_if;
    logic       partida;
    logic [6:0] dados_ascii;
    logic       saida_serial;
    logic       pronto;
    logic [3:0] db_estado;

    // Control unit side
    modport master (
        output partida,
        output dados_ascii,
        input  saida_serial,
        input  pronto,
        input  db_estado
    );

    // Transmitter side
    modport slave (
        input  partida,
        input  dados_ascii,
        output saida_serial,
        output pronto,
        output db_estado
    );
endinterface

// File: rtl/tx_serial_7o1.sv
// 7O1 asynchronous serial transmitter: start bit, 7 data bits LSB first, odd parity, 1 stop bit.
// Each bit lasts BAUD_DIV clocks. saida_serial and pronto come straight from flops.
module tx_serial_7o1 #(
    parameter int BAUD_DIV   = 434,
    parameter int BAUD_CNT_W = 9
) (
    input  logic            clock,
    input  logic            reset,
    tx_serial_7o1_if.slave  bus
);

    typedef enum logic [3:0] {
        REPOUSO     = 4'h0,
        PREPARACAO  = 4'h1,
        TRANSMISSAO = 4'h2,
        FINAL       = 4'hF
    } estado_t;

    localparam logic [BAUD_CNT_W-1:0] BAUD_MAX = BAUD_CNT_W'(BAUD_DIV - 1);

    estado_t               estado;
    logic [BAUD_CNT_W-1:0] baud_cnt;
    logic [3:0]            bit_cnt;
    logic [9:0]            shift_reg;
    logic                  saida_q;
    logic                  pronto_q;

    // Frame sequencer. saida_q follows shift_reg[0] one cycle late, so the frame on
    // the wire starts one cycle after transmissao is entered. After the tenth shift
    // the state stays in transmissao for one extra cycle (bit_cnt == 10). This lets
    // the stop bit finish on the wire before final raises pronto.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= REPOUSO;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            saida_q   <= 1'b1;
            pronto_q  <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            case (estado)
                REPOUSO: begin
                    saida_q <= 1'b1;
                    if (bus.partida) begin
                        estado <= PREPARACAO;
                    end
                end
                PREPARACAO: begin
                    shift_reg <= {1'b1, ~^bus.dados_ascii, bus.dados_ascii, 1'b0};
                    baud_cnt  <= '0;
                    bit_cnt   <= '0;
                    saida_q   <= 1'b1;
                    estado    <= TRANSMISSAO;
                end
                TRANSMISSAO: begin
                    saida_q <= shift_reg[0];
                    if (bit_cnt == 4'd10) begin
                        estado   <= FINAL;
                        pronto_q <= 1'b1;
                    end else if (baud_cnt == BAUD_MAX) begin
                        shift_reg <= {1'b1, shift_reg[9:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                        baud_cnt  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                FINAL: begin
                    saida_q <= 1'b1;
                    estado  <= REPOUSO;
                end
                default: begin
                    saida_q <= 1'b1;
                    estado  <= REPOUSO;
                end
            endcase
        end
    end

    // Debug view of the state register; 4'hE flags an encoding outside the enum.
    always_comb begin
        bus.db_estado = 4'hE;
        case (estado)
            REPOUSO:     bus.db_estado = 4'h0;
            PREPARACAO:  bus.db_estado = 4'h1;
            TRANSMISSAO: bus.db_estado = 4'h2;
            FINAL:       bus.db_estado = 4'hF;
            default:     bus.db_estado = 4'hE;
        endcase
    end

    assign bus.saida_serial = saida_q;
    assign bus.pronto       = pronto_q;

endmodule
